// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared defaults and counter-width helper for the FIFO drain stage
package fifo_stream_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_RD_LAT     = 2;
   localparam int DEF_BUF_DEPTH  = 4;
   localparam int DEF_BURST_LEN  = 4;

   // Bits needed to hold any count from 0 to n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - read-latency valid shift pipe with in-flight popcount
module rd_lat_pipe #(
   parameter int RD_LAT = 2,
   parameter int CNT_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue,
   output logic             tap,
   output logic [CNT_W-1:0] inflight
);

   logic [RD_LAT-1:0] pipe;

   // Shift each issued read toward the tap; tap marks the cycle its word is on the FIFO bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe <= '0;
      end else begin
         pipe[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // Count reads still owed a buffer slot, including the one currently at the tap.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNT_W'(pipe[i]);
      end
   end

   assign tap = pipe[RD_LAT-1];

endmodule

// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - credit-protected FIFO read drain onto a valid/ready burst stream
module fifo_stream_drain
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
   parameter int BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  err_ovf
);

   localparam int CNT_W  = cnt_width(BUF_DEPTH);
   localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      occ;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W:0]        credit_sum;
   logic [BEAT_W-1:0]     beat;
   logic                  tap;
   logic                  full;
   logic                  accept;
   logic                  pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   rd_lat_pipe #(
      .RD_LAT (RD_LAT),
      .CNT_W  (CNT_W)
   ) u_rd_lat_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    (r_en),
      .tap      (tap),
      .inflight (inflight)
   );

   // Every issued read holds a buffer slot until it is popped, so capture can never overflow.
   assign credit_sum = {1'b0, inflight} + {1'b0, occ};
   assign r_en       = rst_n && !fifo_empty && (credit_sum < (CNT_W+1)'(BUF_DEPTH));

   assign full    = (occ == CNT_W'(BUF_DEPTH));
   assign accept  = tap && !full;
   assign m_valid = (occ != '0);
   assign pop     = m_valid && m_ready;
   assign m_data  = mem[rd_ptr];
   assign m_last  = m_valid && (beat == BEAT_W'(BURST_LEN - 1));

   // Circular buffer: capture returning words, release them on handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (accept) begin
            mem[wr_ptr] <= fifo_rd_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({accept, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Burst position advances per handshake and wraps after the final beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat <= '0;
      end else if (pop) begin
         beat <= (beat == BEAT_W'(BURST_LEN - 1)) ? '0 : beat + 1'b1;
      end
   end

   // A word arriving with no free slot is dropped and flagged until reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
      end else if (tap && full) begin
         err_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb/tb_fifo_stream_drain.sv - scoreboard bench for fifo_stream_drain behind an 8-deep FIFO model
module tb_fifo_stream_drain;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       r_en;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_last;
   logic       err_ovf;

   logic       w_en = 1'b0;
   logic [7:0] w_data = 8'h00;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ren_cnt = 0;
   int rdy_mode = 0;
   int exp_beat = 0;
   exp_t sb_q[$];

   bit meas = 1'b0;
   int first_ren = -1;
   int first_val = -1;
   int first_hs = -1;
   int last_hs = -1;
   int hs_cnt = 0;

   // FIFO model: DEPTH 8, two-cycle read latency
   logic [7:0] fmem [8];
   int fwp, frp, fcnt;
   logic [7:0] d1, d2;

   fifo_stream_drain #(
      .DATA_WIDTH (8),
      .RD_LAT     (2),
      .BUF_DEPTH  (4),
      .BURST_LEN  (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .r_en         (r_en),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .err_ovf      (err_ovf)
   );

   always #5 clk = ~clk;

   assign fifo_empty   = (fcnt == 0);
   assign fifo_rd_data = d2;

   // FIFO model storage and read-latency pipe
   always @(posedge clk) begin
      if (!rst_n) begin
         fwp <= 0; frp <= 0; fcnt <= 0; d1 <= 8'h00; d2 <= 8'h00;
      end else begin
         d2 <= d1;
         if (w_en && fcnt < 8) begin
            fmem[fwp] <= w_data;
            fwp <= (fwp + 1) % 8;
         end
         if (r_en && fcnt > 0) begin
            d1 <= fmem[frp];
            frp <= (frp + 1) % 8;
         end
         fcnt <= fcnt + ((w_en && fcnt < 8) ? 1 : 0) - ((r_en && fcnt > 0) ? 1 : 0);
      end
   end

   // Cycle counter and consumer ready pattern
   always @(posedge clk) begin
      cyc++;
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pop expected beat on every handshake, track issue/latency statistics
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (r_en) begin
            ren_cnt++;
            if (meas && first_ren < 0) first_ren = cyc;
         end
         if (meas && m_valid && first_val < 0) first_val = cyc;
         if (m_valid && m_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got data=%02h last=%0b, required no beat", m_data, m_last);
            end else begin
               e = sb_q.pop_front();
               if (m_data !== e.data || m_last !== e.last) begin
                  errors++;
                  $display("FAIL scoreboard: got data=%02h last=%0b, required data=%02h last=%0b",
                           m_data, m_last, e.data, e.last);
               end
            end
            if (meas) begin
               if (first_hs < 0) first_hs = cyc;
               last_hs = cyc;
               hs_cnt++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [7:0] d);
      exp_t e;
      e.data = d;
      e.last = (exp_beat == 3);
      sb_q.push_back(e);
      exp_beat = (exp_beat + 1) % 4;
   endtask

   task automatic write_seq(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         w_en = 1'b1;
         w_data = base + 8'(i);
         push_exp(w_data);
      end
      @(posedge clk); #1;
      w_en = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb_q.size());
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int base;
      int sent;
      int guard;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_r_en", r_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
      check("rst_err_ovf", err_ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Streaming burst at full rate
      rdy_mode = 1;
      meas = 1'b1;
      write_seq(8'h10, 8);
      drain("stream", 100);
      meas = 1'b0;
      check("first_valid_latency", 32'(first_val - first_ren), 3);
      check("stream_beats", 32'(hs_cnt), 8);
      check("stream_back_to_back", 32'(last_hs - first_hs), 7);

      // Backpressure: credit stops issue at buffer depth, outputs hold steady
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      base = ren_cnt;
      write_seq(8'h20, 8);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("bp_reads_issued", 32'(ren_cnt - base), 4);
      check("bp_r_en_low", r_en, 0);
      check("bp_err_ovf", err_ovf, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_m_valid", m_valid, 1);
         check("hold_m_data", m_data, sb_q[0].data);
         check("hold_m_last", m_last, sb_q[0].last);
      end
      rdy_mode = 1;
      drain("bp", 200);

      // Random consumer over 200 words
      rdy_mode = 2;
      sent = 0;
      guard = 0;
      while (sent < 200 && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
         if (fcnt < 8) begin
            w_en = 1'b1;
            w_data = 8'($urandom_range(0, 255));
            push_exp(w_data);
            sent++;
         end else begin
            w_en = 1'b0;
         end
      end
      @(posedge clk); #1;
      w_en = 1'b0;
      check("rand_words_sent", 32'(sent), 200);
      drain("rand", 5000);
      @(negedge clk);
      check("rand_err_ovf", err_ovf, 0);

      // Single word into empty FIFO
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      base = ren_cnt;
      write_seq(8'h5a, 1);
      repeat (10) @(posedge clk);
      check("single_r_en_pulses", 32'(ren_cnt - base), 1);
      drain("single", 50);

      // Reset with reads in flight and a partly filled buffer, mid-burst
      write_seq(8'h60, 2);
      drain("pre_rst", 50);
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      write_seq(8'h70, 4);
      rst_n = 1'b0;
      sb_q.delete();
      exp_beat = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_m_valid", m_valid, 0);
      check("post_rst_r_en", r_en, 0);
      check("post_rst_m_last", m_last, 0);
      check("post_rst_m_data", m_data, 0);
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      write_seq(8'h80, 4);
      drain("post_rst", 100);
      @(negedge clk);
      check("final_err_ovf", err_ovf, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
